// File: rtl/ex_muldiv_sequencer.sv
// rtl/ex_muldiv_sequencer.sv - iterative multiply/divide unit with architectural HI/LO
//
// Purpose: sequential shift-add multiplier and restoring divider for the EX stage.
//          One partial product / quotient bit per cycle, NB_DATA cycles of CALC,
//          then one DONE cycle where the result is shown and committed to HI/LO.
// Ports:
//   i_clk, i_rst_n      clock, synchronous active-low reset
//   i_start, i_md_op    issue request and operation (01 MULT, 10 DIV, else none)
//   i_signed            signed (1) / unsigned (0) operation
//   i_rs, i_rt          multiplicand/dividend, multiplier/divisor
//   i_mthi, i_mtlo      write i_rs into HI / LO (honored only when idle)
//   i_mf_req            EX stage reads HI/LO this cycle
//   i_flush             abort the operation in progress
//   o_hi, o_lo          HI / LO contents (new result visible during DONE)
//   o_busy, o_done      unit busy (CALC/DONE), one-cycle commit pulse
//   o_stall             freeze request while busy and the pipeline needs the unit
module ex_muldiv_sequencer #(
   parameter int NB_DATA  = 32,
   parameter int NB_MD_OP = 2
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic                i_start,
   input  logic [NB_MD_OP-1:0] i_md_op,
   input  logic                i_signed,
   input  logic [NB_DATA-1:0]  i_rs,
   input  logic [NB_DATA-1:0]  i_rt,
   input  logic                i_mthi,
   input  logic                i_mtlo,
   input  logic                i_mf_req,
   input  logic                i_flush,
   output logic [NB_DATA-1:0]  o_hi,
   output logic [NB_DATA-1:0]  o_lo,
   output logic                o_busy,
   output logic                o_done,
   output logic                o_stall
);

   localparam int NB_CNT = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;
   localparam logic [NB_MD_OP-1:0] OP_MULT = NB_MD_OP'(1);
   localparam logic [NB_MD_OP-1:0] OP_DIV  = NB_MD_OP'(2);
   localparam logic [NB_CNT-1:0]   CNT_LAST = NB_CNT'(NB_DATA - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_DONE} state_t;

   state_t              state_q;
   logic [NB_CNT-1:0]   cnt_q;
   logic                is_div_q;
   logic                neg_q;      // negate product / quotient
   logic                rem_neg_q;  // remainder takes the dividend's sign
   logic [NB_DATA-1:0]  work_hi_q;  // product upper half / partial remainder
   logic [NB_DATA-1:0]  work_lo_q;  // multiplier being consumed / dividend -> quotient
   logic [NB_DATA-1:0]  b_q;        // multiplicand / divisor magnitude
   logic [NB_DATA-1:0]  hi_q, lo_q;
   logic                done_q;

   logic                issue;
   logic                rs_neg, rt_neg;
   logic [NB_DATA-1:0]  rs_mag, rt_mag;
   logic [NB_DATA:0]    mul_sum;
   logic [2*NB_DATA-1:0] mul_next, fin_prod;
   logic [NB_DATA:0]    div_trial;
   logic                div_ok;
   logic [NB_DATA-1:0]  div_rem_next, div_quo_next, fin_quo, fin_rem;

   always_comb begin
      issue  = i_start && !i_flush && (i_md_op == OP_MULT || i_md_op == OP_DIV);
      rs_neg = i_signed && i_rs[NB_DATA-1];
      rt_neg = i_signed && i_rt[NB_DATA-1];
      rs_mag = rs_neg ? (~i_rs + 1'b1) : i_rs;
      rt_mag = rt_neg ? (~i_rt + 1'b1) : i_rt;

      // Shift-add: add multiplicand when the current multiplier bit is set,
      // then shift the whole product right, carry included.
      mul_sum  = {1'b0, work_hi_q} + (work_lo_q[0] ? {1'b0, b_q} : '0);
      mul_next = {mul_sum, work_lo_q[NB_DATA-1:1]};
      fin_prod = neg_q ? (~mul_next + 1'b1) : mul_next;

      // Restoring divide: bring in the next dividend bit, keep the difference
      // only if it did not borrow (top bit of the trial is the borrow).
      div_trial    = {work_hi_q, work_lo_q[NB_DATA-1]} - {1'b0, b_q};
      div_ok       = !div_trial[NB_DATA];
      div_rem_next = div_ok ? div_trial[NB_DATA-1:0]
                            : {work_hi_q[NB_DATA-2:0], work_lo_q[NB_DATA-1]};
      div_quo_next = {work_lo_q[NB_DATA-2:0], div_ok};
      fin_quo      = neg_q ? (~div_quo_next + 1'b1) : div_quo_next;
      fin_rem      = rem_neg_q ? (~div_rem_next + 1'b1) : div_rem_next;
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         is_div_q  <= 1'b0;
         neg_q     <= 1'b0;
         rem_neg_q <= 1'b0;
         work_hi_q <= '0;
         work_lo_q <= '0;
         b_q       <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         done_q    <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               done_q <= 1'b0;
               if (i_mthi) hi_q <= i_rs;
               if (i_mtlo) lo_q <= i_rs;
               if (issue) begin
                  state_q   <= ST_CALC;
                  cnt_q     <= '0;
                  is_div_q  <= (i_md_op == OP_DIV);
                  // A zero divisor keeps the quotient unnegated so it stays
                  // all ones, and the remainder naturally reproduces i_rs.
                  // Most-negative / -1 yields most-negative with remainder 0
                  // from the magnitude path without special handling.
                  neg_q     <= (rs_neg ^ rt_neg) && !(i_md_op == OP_DIV && i_rt == '0);
                  rem_neg_q <= rs_neg;
                  work_hi_q <= '0;
                  work_lo_q <= (i_md_op == OP_DIV) ? rs_mag : rt_mag;
                  b_q       <= (i_md_op == OP_DIV) ? rt_mag : rs_mag;
               end
            end
            ST_CALC: begin
               if (i_flush) begin
                  state_q <= ST_IDLE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
                  if (cnt_q == CNT_LAST) begin
                     state_q <= ST_DONE;
                     done_q  <= 1'b1;
                     if (is_div_q) begin
                        work_hi_q <= fin_rem;
                        work_lo_q <= fin_quo;
                     end else begin
                        {work_hi_q, work_lo_q} <= fin_prod;
                     end
                  end else if (is_div_q) begin
                     work_hi_q <= div_rem_next;
                     work_lo_q <= div_quo_next;
                  end else begin
                     {work_hi_q, work_lo_q} <= mul_next;
                  end
               end
            end
            default: begin
               // DONE: the result is architecturally written on leaving,
               // so a flush here leaves HI/LO at their pre-issue values.
               state_q <= ST_IDLE;
               done_q  <= 1'b0;
               if (!i_flush) begin
                  hi_q <= work_hi_q;
                  lo_q <= work_lo_q;
               end
            end
         endcase
      end
   end

   assign o_busy  = (state_q != ST_IDLE);
   assign o_done  = done_q && !i_flush;
   assign o_hi    = (state_q == ST_DONE) ? work_hi_q : hi_q;
   assign o_lo    = (state_q == ST_DONE) ? work_lo_q : lo_q;
   assign o_stall = o_busy && (i_start || i_mf_req || i_mthi || i_mtlo);

endmodule

// File: tb/tb_ex_muldiv_sequencer.sv
// tb/tb_ex_muldiv_sequencer.sv - self-checking bench for ex_muldiv_sequencer
module tb_ex_muldiv_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [1:0]  md_op;
   logic        sgn;
   logic [31:0] rs, rt;
   logic        mthi, mtlo, mf_req, flush;
   logic [31:0] hi, lo;
   logic        busy, done, stall;

   int vec_cnt = 0;
   int err_cnt = 0;

   always #5 clk = ~clk;

   ex_muldiv_sequencer #(.NB_DATA(32), .NB_MD_OP(2)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_md_op(md_op),
      .i_signed(sgn), .i_rs(rs), .i_rt(rt), .i_mthi(mthi), .i_mtlo(mtlo),
      .i_mf_req(mf_req), .i_flush(flush), .o_hi(hi), .o_lo(lo),
      .o_busy(busy), .o_done(done), .o_stall(stall)
   );

   typedef struct {
      string       name;
      logic [1:0]  op;
      logic        sgn;
      logic [31:0] rs;
      logic [31:0] rt;
      logic [31:0] exp_hi;
      logic [31:0] exp_lo;
   } vec_t;

   vec_t vecs[12];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      start = 0; md_op = 0; sgn = 0; rs = 0; rt = 0;
      mthi = 0; mtlo = 0; mf_req = 0; flush = 0;
   endtask

   // Drive issue in the current cycle (N); returns on the negedge of cycle N.
   task automatic issue(input logic [1:0] op, input logic s, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      start = 1; md_op = op; sgn = s; rs = a; rt = b;
   endtask

   task automatic run_vec(input vec_t v);
      int lat;
      lat = 0;
      issue(v.op, v.sgn, v.rs, v.rt);
      for (int k = 1; k <= 40 && lat == 0; k++) begin
         @(negedge clk);
         start = 0; md_op = 0; rs = 0; rt = 0;
         #1;
         if (done) begin
            lat = k;
            check({v.name, " hi"}, hi, v.exp_hi);
            check({v.name, " lo"}, lo, v.exp_lo);
         end
      end
      check({v.name, " latency"}, 32'(lat), 32'd33);
      @(negedge clk); #1;
      check({v.name, " committed hi"}, hi, v.exp_hi);
      check({v.name, " committed lo"}, lo, v.exp_lo);
      check({v.name, " idle"}, {31'd0, busy}, 32'd0);
   endtask

   initial begin
      vecs[0]  = '{"multu_ff_x2",   2'b01, 1'b0, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE};
      vecs[1]  = '{"mult_m1_x2",    2'b01, 1'b1, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE};
      vecs[2]  = '{"mult_m3_xm5",   2'b01, 1'b1, 32'hFFFFFFFD, 32'hFFFFFFFB, 32'h00000000, 32'h0000000F};
      vecs[3]  = '{"multu_2p32",    2'b01, 1'b0, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};
      vecs[4]  = '{"mult_minsq",    2'b01, 1'b1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
      vecs[5]  = '{"div_m7_2",      2'b10, 1'b1, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
      vecs[6]  = '{"divu_100_7",    2'b10, 1'b0, 32'd100,      32'd7,        32'd2,        32'd14};
      vecs[7]  = '{"div_7_m2",      2'b10, 1'b1, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};
      vecs[8]  = '{"divu_by0",      2'b10, 1'b0, 32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF};
      vecs[9]  = '{"div_m5_by0",    2'b10, 1'b1, 32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF};
      vecs[10] = '{"div_overflow",  2'b10, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
      vecs[11] = '{"divu_ff_1",     2'b10, 1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF};

      idle_inputs();
      rst_n = 0;
      repeat (3) @(negedge clk);
      #1;
      check("reset hi", hi, 32'd0);
      check("reset lo", lo, 32'd0);
      check("reset busy", {31'd0, busy}, 32'd0);
      check("reset done", {31'd0, done}, 32'd0);
      check("reset stall", {31'd0, stall}, 32'd0);
      @(negedge clk);
      rst_n = 1;

      foreach (vecs[i]) run_vec(vecs[i]);

      // mthi and mtlo together write both registers
      @(negedge clk);
      rs = 32'hCAFE0001; mthi = 1; mtlo = 1;
      @(negedge clk);
      mthi = 0; mtlo = 0; rs = 0; #1;
      check("mthi+mtlo hi", hi, 32'hCAFE0001);
      check("mthi+mtlo lo", lo, 32'hCAFE0001);

      // op 00 and op 11 are not issued
      issue(2'b00, 1'b0, 32'd5, 32'd6);
      @(negedge clk); start = 0; #1;
      check("op00 busy", {31'd0, busy}, 32'd0);
      issue(2'b11, 1'b0, 32'd5, 32'd6);
      @(negedge clk); start = 0; #1;
      check("op11 busy", {31'd0, busy}, 32'd0);
      check("op11 lo", lo, 32'hCAFE0001);

      // flush together with start rejects the issue
      issue(2'b01, 1'b0, 32'd5, 32'd6);
      flush = 1;
      @(negedge clk); start = 0; flush = 0; #1;
      check("flush+start busy", {31'd0, busy}, 32'd0);

      // stall on read: mf_req from N+5 onward
      begin
         issue(2'b01, 1'b1, 32'd3, 32'd4);
         for (int k = 1; k <= 34; k++) begin
            @(negedge clk);
            start = 0;
            mf_req = (k >= 5);
            #1;
            check($sformatf("stall k=%0d", k), {31'd0, stall}, {31'd0, (k >= 5 && k <= 33)});
         end
         mf_req = 0;
         check("stall result lo", lo, 32'd12);
      end

      // start while busy is ignored, not queued
      begin
         int lat;
         lat = 0;
         issue(2'b01, 1'b0, 32'd3, 32'd4);
         for (int k = 1; k <= 40 && lat == 0; k++) begin
            @(negedge clk);
            start = (k == 5); md_op = 2'b10; rs = 32'd100; rt = 32'd3;
            #1;
            if (k == 5) check("busy start stalls", {31'd0, stall}, 32'd1);
            if (done) lat = k;
         end
         start = 0;
         check("busy start latency", 32'(lat), 32'd33);
         check("busy start lo", lo, 32'd12);
         @(negedge clk); #1;
         check("busy start not queued", {31'd0, busy}, 32'd0);
      end

      // flush mid-operation
      begin
         bit seen;
         seen = 0;
         @(negedge clk);
         rs = 32'hAAAA5555; mtlo = 1;
         @(negedge clk);
         mtlo = 0; #1;
         check("mtlo lo", lo, 32'hAAAA5555);
         issue(2'b10, 1'b0, 32'd1000, 32'd7);
         for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            start = 0;
            flush = (k == 10);
            #1;
            if (done) seen = 1;
            if (k == 11) check("flush idle", {31'd0, busy}, 32'd0);
         end
         flush = 0;
         check("flush no done", {31'd0, seen}, 32'd0);
         check("flush lo kept", lo, 32'hAAAA5555);
      end

      // reset during CALC
      begin
         bit seen;
         seen = 0;
         @(negedge clk);
         rs = 32'h0000BEEF; mthi = 1;
         @(negedge clk);
         mthi = 0;
         issue(2'b01, 1'b0, 32'd9, 32'd9);
         for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            start = 0;
            rst_n = (k != 20);
            #1;
            if (done) seen = 1;
            if (k == 21) begin
               check("rst busy", {31'd0, busy}, 32'd0);
               check("rst hi", hi, 32'd0);
               check("rst lo", lo, 32'd0);
            end
         end
         check("rst no done", {31'd0, seen}, 32'd0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
